// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - registered instruction sequencer: PC, return-address stack, fetch handshake, decode bundle
// Optional feature: define STACK_GUARD_EN to trap stack overflow/underflow into a sticky FAULT state.
module instr_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic                         fetch_req,
  output logic [ADDR_W-1:0]            fetch_addr,
  output logic [ADDR_W-1:0]            fetch_addr_n,
  input  logic                         fetch_ack,
  input  logic [DATA_W-1:0]            instr,
  input  logic [DATA_W-1:0]            n,
  input  logic [ADDR_W-1:0]            rddata,
  input  logic                         jump,
  input  logic                         resume,
  output logic                         dec_valid,
  output logic [4:0]                   dec_op,
  output logic [4:0]                   dec_func,
  output logic [DATA_W-1:0]            dec_imm,
  output logic                         dec_use_imm,
  output logic [ADDR_W-1:0]            pc,
  output logic                         halted,
  output logic                         fault,
  output logic [$clog2(STACK_DEPTH):0] sp
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Field extraction; the length bit is the lowest opcode bit (selects the 2-word form)
  logic [4:0]        op;
  logic [4:0]        func;
  logic              len_bit;
  logic [ADDR_W-1:0] n_addr;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] sub_skip;
  logic              unused_bits;

  assign op          = instr[DATA_W-1 -: 5];
  assign func        = instr[4:0];
  assign len_bit     = instr[DATA_W-5];
  assign n_addr      = ADDR_W'(n);
  assign br_off      = ADDR_W'(instr[1:0]);
  assign len         = ADDR_W'(len_bit) + ADDR_W'(1);
  assign sub_skip    = (op[4:1] == 4'b0101 && func[1] && jump) ? ADDR_W'(func[0]) + ADDR_W'(1) : '0;
  assign unused_bits = ^{instr, n};

  // Return-address stack storage and pointers
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] push_addr;
  logic [SP_W-1:0]   sp_inc;
  logic [SP_W-1:0]   sp_dec;

  assign ptr       = sp[PTR_W-1:0];
  assign rd_idx    = ptr - PTR_W'(1);
  assign stack_top = stack_mem[rd_idx];
  assign push_addr = pc + ADDR_W'(2);

  // Decode results
  logic [ADDR_W-1:0] pc_calc;
  logic              use_imm;
  logic              is_stop;
  logic              push;
  logic              pop;
  logic              guard_hit;
  logic              accept;
  logic              issue;

  // Instruction decode: next pc, operand use and stack action for the word pair on the bus
  always_comb begin
    pc_calc = pc + ADDR_W'(1);
    use_imm = 1'b0;
    is_stop = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    casez (op)
      5'b00000: pc_calc = pc + ADDR_W'(1);
      5'b11111: is_stop = 1'b1;
      5'b00001: begin
        push    = 1'b1;
        use_imm = 1'b1;
        pc_calc = n_addr;
      end
      5'b11100: begin
        pop     = 1'b1;
        pc_calc = stack_top;
      end
      5'b00100: pc_calc = rddata;
      5'b00101: begin
        use_imm = 1'b1;
        pc_calc = n_addr;
      end
      5'b00010: pc_calc = jump ? pc + ADDR_W'(2) + br_off : pc + ADDR_W'(1);
      5'b00011: begin
        use_imm = 1'b1;
        pc_calc = jump ? pc + ADDR_W'(3) + br_off : pc + ADDR_W'(2);
      end
      5'b01???: begin
        use_imm = len_bit;
        pc_calc = pc + len + sub_skip;
      end
      5'b10???: begin
        use_imm = len_bit;
        pc_calc = pc + len;
      end
      5'b110?0: pc_calc = pc + ADDR_W'(1);
      default:  is_stop = 1'b1;
    endcase
  end

`ifdef STACK_GUARD_EN
  assign guard_hit = (push && sp == SP_W'(STACK_DEPTH)) || (pop && sp == '0);
  assign sp_inc    = sp + SP_W'(1);
  assign sp_dec    = sp - SP_W'(1);
`else
  assign guard_hit = 1'b0;
  assign sp_inc    = {1'b0, ptr + PTR_W'(1)};
  assign sp_dec    = {1'b0, ptr - PTR_W'(1)};
`endif

  assign accept = (state == ST_RUN) && fetch_ack;
  assign issue  = accept && !is_stop && !guard_hit;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Next-state logic: STP/unknown opcodes halt, stack guard traps, resume leaves HALT only
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (accept && is_stop)        state_nxt = ST_HALT;
        else if (accept && guard_hit) state_nxt = ST_FAULT;
      end
      ST_HALT:  if (resume) state_nxt = ST_RUN;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // State-derived outputs
  always_comb begin
    fetch_req = (state == ST_RUN);
    halted    = (state == ST_HALT);
`ifdef STACK_GUARD_EN
    fault     = (state == ST_FAULT);
`else
    fault     = 1'b0;
`endif
  end

  assign fetch_addr   = pc;
  assign fetch_addr_n = pc + ADDR_W'(1);

  // Datapath: pc, stack pointer and decode bundle advance only on an issued instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      sp          <= '0;
      dec_valid   <= 1'b0;
      dec_op      <= '0;
      dec_func    <= '0;
      dec_imm     <= '0;
      dec_use_imm <= 1'b0;
    end else begin
      dec_valid <= issue;
      if (issue) begin
        pc          <= pc_calc;
        dec_op      <= op;
        dec_func    <= func;
        dec_use_imm <= use_imm;
        dec_imm     <= use_imm ? n : '0;
        if (push)     sp <= sp_inc;
        else if (pop) sp <= sp_dec;
      end
    end
  end

  // Stack write on CALL; contents need no reset since sp gates every read
  always_ff @(posedge clk) begin
    if (issue && push) stack_mem[ptr] <= push_addr;
  end

endmodule
